// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, datapath width, output-register states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared ALU arbiter.
// Latency: n/a (wiring only).
// Backpressure: per-requester valid/ready on the request side, valid/ready on the response side.
// Ports (slave = arbiter side):
//   req_valid/req_a/req_b/req_sel in, req_ready out; rsp_ready in, rsp_valid/rsp_result/rsp_id/op_count out.
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ*3-1:0] req_sel;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_result;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id, op_count
  );

endinterface

// File: rtl/alu.sv
// Purely combinational 8-bit ALU: add/sub wrap, logic ops, not-A, 1-bit zero-fill shifts of A.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: a, b operands; sel opcode; y result.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       sel,
  output logic [ALU_W-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOT: y = ~a;
      ALU_SHL: y = {a[ALU_W-2:0], 1'b0};
      ALU_SHR: y = {1'b0, a[ALU_W-1:1]};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, with a one-deep result register.
// Latency: 1 cycle from request transfer to rsp_valid; one op per cycle while rsp_ready is high.
// Backpressure: req_ready is withheld while the result register is full and rsp_ready is low.
// Ports: clk, rst_n (async active-low); bus (alu_arbiter_if.slave) carries requests, response and op_count.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic             can_issue;
  logic             xfer;
  logic [ALU_W-1:0] mux_a;
  logic [ALU_W-1:0] mux_b;
  logic [2:0]       mux_sel;
  logic [ALU_W-1:0] alu_y;
  logic [ALU_W-1:0] result_q;
  logic [IDW-1:0]   id_q;
  logic [15:0]      count_q;
  out_state_e       state;
  out_state_e       state_nxt;

  // (base + step) mod NREQ without relying on NREQ being a power of two.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  assign can_issue = (state == ST_EMPTY) || bus.rsp_ready;

  // Search starts one past the last winner; the last winner itself is checked last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_found && bus.req_valid[rr_index(last_grant, k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_index(last_grant, k);
      end
    end
  end

  // rst_n gates ready so nothing looks accepted while reset is held.
  assign xfer = rst_n && can_issue && grant_found;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[grant_idx] = 1'b1;
  end

  // Operand mux; deliberately independent of the ready path.
  always_comb begin
    mux_a   = '0;
    mux_b   = '0;
    mux_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        mux_a   = bus.req_a[i*ALU_W +: ALU_W];
        mux_b   = bus.req_b[i*ALU_W +: ALU_W];
        mux_sel = bus.req_sel[i*3 +: 3];
      end
    end
  end

  alu u_alu (
    .a   (mux_a),
    .b   (mux_b),
    .sel (mux_sel),
    .y   (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.rsp_valid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (xfer) state_nxt = ST_FULL;
      end
      ST_FULL: begin
        bus.rsp_valid = 1'b1;
        // A simultaneous transfer refills the register, so it stays FULL.
        if (!xfer && bus.rsp_ready) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(NREQ - 1);
      result_q   <= '0;
      id_q       <= '0;
      count_q    <= '0;
    end else if (xfer) begin
      last_grant <= grant_idx;
      result_q   <= alu_y;
      id_q       <= grant_idx;
      if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  assign bus.rsp_result = result_q;
  assign bus.rsp_id     = id_q;
  assign bus.op_count   = count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: rsp_ready is driven both constant and randomly.
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst_n;

  alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state.
  bit       m_valid;
  int       m_result;
  int       m_id;
  int       m_count;
  int       m_last;
  int       m_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 255 - a;
      6: return (a * 2) % 256;
      default: return a / 2;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v == (NREQ'(1) << i)) return i;
    return -1;
  endfunction

  task automatic set_req(input int i, input int a, input int b, input int op);
    bus.req_a[i*8 +: 8]   = 8'(a);
    bus.req_b[i*8 +: 8]   = 8'(b);
    bus.req_sel[i*3 +: 3] = 3'(op);
  endtask

  task automatic model_reset();
    m_valid  = 0;
    m_result = 0;
    m_id     = 0;
    m_count  = 0;
    m_last   = NREQ - 1;
    m_grant  = -1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with inputs already set; checks, crosses one edge, updates the model.
  task automatic run_cycle();
    logic [NREQ-1:0] exp_rdy;
    int g;
    #1;
    exp_rdy = '0;
    g = -1;
    if (!m_valid || bus.rsp_ready) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (g < 0 && bus.req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    check("rsp_result", 32'(bus.rsp_result), 32'(m_result));
    check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
    check("op_count", 32'(bus.op_count), 32'(m_count));
    m_grant = g;
    @(posedge clk);
    if (g >= 0) begin
      m_result = ref_alu(int'(bus.req_a[g*8 +: 8]), int'(bus.req_b[g*8 +: 8]), int'(bus.req_sel[g*3 +: 3]));
      m_id     = g;
      m_valid  = 1;
      m_last   = g;
      if (m_count < 65535) m_count++;
    end else if (bus.rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int vec_a[4]   = '{8'h81, 8'h81, 8'h81, 8'h00};
  int vec_b[4]   = '{8'h00, 8'h00, 8'h00, 8'h01};
  int vec_op[4]  = '{6, 7, 5, 1};
  int vec_exp[4] = '{8'h02, 8'h40, 8'h7E, 8'hFF};

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b0;
    model_reset();

    // Reset state, with requests pending to prove ready is held low.
    repeat (2) @(posedge clk);
    bus.req_valid = '1;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_result", 32'(bus.rsp_result), 32'h0);
    check("rst_id", 32'(bus.rsp_id), 32'h0);
    check("rst_count", 32'(bus.op_count), 32'h0);
    do_reset();

    // Requester 2 alone: F0 + 20 wraps to 10.
    set_req(2, 8'hF0, 8'h20, 0);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    check("r2_ready", 32'(bus.req_ready), 32'b0100);
    run_cycle();
    bus.req_valid = '0;
    #1;
    check("r2_result", 32'(bus.rsp_result), 32'h10);
    check("r2_id", 32'(bus.rsp_id), 32'd2);
    check("r2_count", 32'(bus.op_count), 32'd1);
    check("r2_valid", 32'(bus.rsp_valid), 32'd1);

    // Round-robin order with all requesters active.
    do_reset();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("rr_order", 32'(onehot_idx(bus.req_ready)), 32'(exp_order[c]));
      run_cycle();
      check("rr_valid", 32'(bus.rsp_valid), 32'd1);
    end

    // Hold while FULL and rsp_ready low; held result ignores operand changes.
    do_reset();
    set_req(0, 3, 4, 0);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    run_cycle();
    bus.req_valid = 4'b0010;
    set_req(1, 8'h55, 8'h0F, 2);
    for (int c = 0; c < 3; c++) begin
      set_req(0, c + 9, c + 20, 4);
      run_cycle();
      check("hold_ready", 32'(bus.req_ready), 32'h0);
      check("hold_result", 32'(bus.rsp_result), 32'h07);
      check("hold_id", 32'(bus.rsp_id), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("resume_ready", 32'(bus.req_ready), 32'b0010);
    run_cycle();
    check("resume_result", 32'(bus.rsp_result), 32'h05);

    // Shift / not / sub-wrap vectors on requester 0.
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    for (int v = 0; v < 4; v++) begin
      set_req(0, vec_a[v], vec_b[v], vec_op[v]);
      run_cycle();
      check("vec_result", 32'(bus.rsp_result), 32'(vec_exp[v]));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      bus.req_a     = $urandom;
      bus.req_b     = $urandom;
      bus.req_sel   = 12'($urandom);
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      run_cycle();
    end

    // Asynchronous reset while FULL.
    do_reset();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    run_cycle();
    run_cycle();
    check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_count", 32'(bus.op_count), 32'd0);
    check("arst_ready", 32'(bus.req_ready), 32'h0);
    bus.req_valid = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = '1;
    #1;
    check("arst_grant", 32'(bus.req_ready), 32'b0001);
    run_cycle();

    // Counter saturation: one transfer per cycle from reset.
    do_reset();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("cnt_fffe", 32'(bus.op_count), 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("cnt_sat", 32'(bus.op_count), 32'hFFFF);
    check("cnt_sat_valid", 32'(bus.rsp_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
